// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, ALU command indices and
// operand-select encodings used by the decode/execute boundary.
package riscv_pkg;

    localparam int XLEN         = 32;
    localparam int NB_OPERATION = 5;

    // Bit positions inside the one-hot ALU command vector
    localparam int ALU_ADD = 0;
    localparam int ALU_SLT = 1;
    localparam int ALU_AND = 2;
    localparam int ALU_OR  = 3;
    localparam int ALU_XOR = 4;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'b00,
        OP1_PC   = 2'b01,
        OP1_ZERO = 2'b10
    } op1_sel_e;

    localparam logic OP2_RS2 = 1'b0;
    localparam logic OP2_IMM = 1'b1;

    // Widen to XLEN+1 so the ALU adder's top bit carries the compare result
    function automatic logic [XLEN:0] extend_operand(input logic [XLEN-1:0] value,
                                                     input logic            zero_ext);
        logic [XLEN:0] result;
        if (zero_ext) begin
            result = {1'b0, value};
        end else begin
            result = {value[XLEN-1], value};
        end
        return result;
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// Selects writeback data over register-file data when the writeback port
// targets the same source register; x0 always reads the register file.
module operand_bypass
    import riscv_pkg::*;
(
    input  logic [4:0]      rs_adr,
    input  logic [XLEN-1:0] rs_data,
    input  logic            wb_valid,
    input  logic [4:0]      wb_adr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] rs_value
);

    logic hit_s;

    assign hit_s    = wb_valid & (wb_adr == rs_adr) & (rs_adr != 5'd0);
    assign rs_value = hit_s ? wb_data : rs_data;

endmodule

// File: rtl/exe_operand_stage.sv
// Decode-to-execute pipeline register: picks and extends ALU operands,
// pre-negates operand 2 for subtract/compare, and holds them behind valid/ready.
module exe_operand_stage
    import riscv_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [4:0]              rs1_adr_i,
    input  logic [4:0]              rs2_adr_i,
    input  logic [XLEN-1:0]         rs1_data_i,
    input  logic [XLEN-1:0]         rs2_data_i,
    input  logic [XLEN-1:0]         imm_i,
    input  logic [XLEN-1:0]         pc_i,
    input  logic [1:0]              op1_sel_i,
    input  logic                    op2_sel_i,
    input  logic [NB_OPERATION-1:0] cmd_i,
    input  logic                    sub_i,
    input  logic                    unsigned_i,
    input  logic [4:0]              rd_adr_i,
    input  logic                    rd_wb_i,
    input  logic                    wb_valid_i,
    input  logic [4:0]              wb_adr_i,
    input  logic [XLEN-1:0]         wb_data_i,
    input  logic                    flush_i,
    input  logic                    ready_i,
    output logic                    valid_o,
    output logic                    alu_en_o,
    output logic [XLEN:0]           rs1_data_o,
    output logic [XLEN:0]           rs2_data_o,
    output logic [NB_OPERATION-1:0] cmd_o,
    output logic [4:0]              rd_adr_o,
    output logic                    rd_wb_o
);

    logic [XLEN-1:0]         rs1_value_s;
    logic [XLEN-1:0]         rs2_value_s;
    logic [XLEN-1:0]         op1_s;
    logic [XLEN-1:0]         op2_s;
    logic                    zero_ext_s;
    logic                    negate_s;
    logic [XLEN:0]           op1_ext_s;
    logic [XLEN:0]           op2_ext_s;
    logic [XLEN:0]           op2_final_s;
    logic                    accept_s;

    logic                    valid_r;
    logic [XLEN:0]           rs1_data_r;
    logic [XLEN:0]           rs2_data_r;
    logic [NB_OPERATION-1:0] cmd_r;
    logic [4:0]              rd_adr_r;
    logic                    rd_wb_r;

    operand_bypass u_bypass_rs1 (
        .rs_adr   (rs1_adr_i),
        .rs_data  (rs1_data_i),
        .wb_valid (wb_valid_i),
        .wb_adr   (wb_adr_i),
        .wb_data  (wb_data_i),
        .rs_value (rs1_value_s)
    );

    operand_bypass u_bypass_rs2 (
        .rs_adr   (rs2_adr_i),
        .rs_data  (rs2_data_i),
        .wb_valid (wb_valid_i),
        .wb_adr   (wb_adr_i),
        .wb_data  (wb_data_i),
        .rs_value (rs2_value_s)
    );

    assign ready_o  = ~valid_r | ready_i;
    assign accept_s = valid_i & ready_o & ~flush_i;

    // Operand source selection, extension and optional two's-complement negation
    always_comb begin
        op1_s = {XLEN{1'b0}};
        case (op1_sel_e'(op1_sel_i))
            OP1_RS1:  op1_s = rs1_value_s;
            OP1_PC:   op1_s = pc_i;
            OP1_ZERO: op1_s = {XLEN{1'b0}};
            default:  op1_s = {XLEN{1'b0}};
        endcase

        if (op2_sel_i == OP2_IMM) begin
            op2_s = imm_i;
        end else begin
            op2_s = rs2_value_s;
        end

        zero_ext_s = unsigned_i & cmd_i[ALU_SLT];
        negate_s   = cmd_i[ALU_SLT] | (cmd_i[ALU_ADD] & sub_i);
        op1_ext_s  = extend_operand(op1_s, zero_ext_s);
        op2_ext_s  = extend_operand(op2_s, zero_ext_s);

        if (negate_s) begin
            op2_final_s = (~op2_ext_s) + {{XLEN{1'b0}}, 1'b1};
        end else begin
            op2_final_s = op2_ext_s;
        end
    end

    // Pipeline register: flush and drain clear valid and the write enable, stall holds all
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r    <= 1'b0;
            rs1_data_r <= {(XLEN+1){1'b0}};
            rs2_data_r <= {(XLEN+1){1'b0}};
            cmd_r      <= {NB_OPERATION{1'b0}};
            rd_adr_r   <= 5'd0;
            rd_wb_r    <= 1'b0;
        end else if (flush_i) begin
            valid_r <= 1'b0;
            rd_wb_r <= 1'b0;
        end else if (accept_s) begin
            valid_r    <= 1'b1;
            rs1_data_r <= op1_ext_s;
            rs2_data_r <= op2_final_s;
            cmd_r      <= cmd_i;
            rd_adr_r   <= rd_adr_i;
            rd_wb_r    <= rd_wb_i;
        end else if (ready_i) begin
            valid_r <= 1'b0;
            rd_wb_r <= 1'b0;
        end
    end

    assign valid_o    = valid_r;
    assign alu_en_o   = valid_r;
    assign rs1_data_o = rs1_data_r;
    assign rs2_data_o = rs2_data_r;
    assign cmd_o      = cmd_r;
    assign rd_adr_o   = rd_adr_r;
    assign rd_wb_o    = rd_wb_r;

endmodule

// File: doc/exe_operand_stage.md
Name: exe_operand_stage

Overview:
- Decode-to-execute pipeline register. It feeds the integer ALU directly.
- Selects operand sources (register file, PC, immediate, writeback bypass) and extends operands to XLEN+1 bits.
- Pre-negates operand 2 for subtract/compare, so the ALU's single adder yields both difference and less-than (bit XLEN).
- Registers the result behind a valid/ready handshake with stall and flush.

Parameters:
XLEN, 32 (riscv_pkg), datapath width; operands out are XLEN+1 bits
NB_OPERATION, riscv_pkg value, width of one-hot ALU command vector

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
valid_i  in  1  decode presents an instruction
ready_o  out  1  stage can accept this cycle
rs1_adr_i  in  5  source register 1 index
rs2_adr_i  in  5  source register 2 index
rs1_data_i  in  XLEN  register file read data 1
rs2_data_i  in  XLEN  register file read data 2
imm_i  in  XLEN  sign-extended immediate
pc_i  in  XLEN  instruction PC
op1_sel_i  in  2  op1 source: 00 rs1, 01 pc, 10 zero, 11 reserved (treated as zero)
op2_sel_i  in  1  op2 source: 0 rs2, 1 imm
cmd_i  in  NB_OPERATION  one-hot ALU command (ADD/SLT/AND/OR/XOR)
sub_i  in  1  with ADD: subtract
unsigned_i  in  1  with SLT: unsigned compare (SLTU)
rd_adr_i  in  5  destination register
rd_wb_i  in  1  instruction writes rd
wb_valid_i  in  1  writeback port writing this cycle
wb_adr_i  in  5  writeback destination
wb_data_i  in  XLEN  writeback data
flush_i  in  1  kill held and incoming instruction
ready_i  in  1  execute stage accepts
valid_o  out  1  output register holds a valid instruction
alu_en_o  out  1  equals valid_o; ALU output gate
rs1_data_o  out  XLEN+1  extended operand 1
rs2_data_o  out  XLEN+1  extended, possibly negated operand 2
cmd_o  out  NB_OPERATION  registered command
rd_adr_o  out  5  registered destination
rd_wb_o  out  1  registered write enable, forced 0 when valid_o=0

Behaviour:
- Reset: every output register is 0, so valid_o=alu_en_o=0 and ready_o=1. Reset overrides flush and handshake.
- ready_o = !valid_q | ready_i. This is combinational and does not depend on valid_i.
- Accept when valid_i & ready_o & !flush_i. On accept, all output registers load next edge; latency is 1 cycle.
- Drain when valid_q & ready_i and there is no accept: valid_q <= 0. Data registers may hold stale values, but rd_wb_o and alu_en_o are gated to 0.
- Stall when valid_q & !ready_i: every output holds bit-exact. Operands are frozen; bypass is sampled only at accept.
- Flush: valid_q <= 0 next edge. The incoming instruction is dropped even if handshake conditions hold, and ready_o is unaffected.
- Bypass: rsN value = wb_data_i when wb_valid_i & wb_adr_i==rsN_adr_i & rsN_adr_i!=0, else rsN_data_i. x0 is never bypassed.
- op1 = selected XLEN value.
- op2 = rs2 value or imm_i.
- ext = unsigned_i & cmd_i[SLT]. The extension bit is 0 if ext, else the source MSB. It applies to both operands.
- Negate when cmd_i[SLT] | (cmd_i[ADD] & sub_i): rs2_data_o = (~ext(op2)) + 1, computed modulo 2^(XLEN+1).
- Negation gives ALU bit XLEN = less-than for both signed and unsigned operands. No overflow is possible.
- Non-negated op2: rs2_data_o = ext(op2).
- sub_i with a command other than ADD is ignored.
- More than one cmd_i bit set is illegal; the stage registers it unchanged, with no check.

Decomposition:
- riscv_pkg gets the op1_sel encoding enum (OP1_RS1, OP1_PC, OP1_ZERO) and OP2_RS2/OP2_IMM.
- The ADD/SLT/AND/OR/XOR command indices already live there and are reused.
- One sub-module is natural: operand_bypass (pure combinational compare+mux), instantiated twice.
- Handshake, extension/negation and registers stay in the top module.

Test Plan:
- SLT signed: rs1=0xFFFFFFFF, rs2=0x00000001, accept with ready_i=1. Next cycle rs1_data_o=0x1FFFFFFFF, rs2_data_o=0x1FFFFFFFF, and their sum has bit32=1.
- SLTU: same operands, unsigned_i=1. rs1_data_o=0x0FFFFFFFF, rs2_data_o=0x1FFFFFFFF, sum bit32=0.
- Sub/bypass: ADD+sub_i, rs1_adr=5, rs1_data_i=7, wb_valid_i=1, wb_adr=5, wb_data=20, imm_i=3, op2_sel=imm. rs1_data_o=20 and rs2_data_o=0x1FFFFFFFD. Repeat with rs1_adr=wb_adr=0 and rs1_data_i=0: rs1_data_o=0.
- Stall: accept, then hold ready_i=0 for 3 cycles while toggling all inputs and wb_*. Outputs stay constant and ready_o=0. Raise ready_i with valid_i=1 and the new instruction loads the next edge.
- Flush: valid_q=1, ready_i=0, flush_i=1 with valid_i=1. Next cycle valid_o=0 and rd_wb_o=0, and the incoming instruction never appears.
- Reset: assert reset mid-stall with valid_q=1. Next edge all outputs are 0 and ready_o=1, even with flush_i=1 and valid_i=1 applied together.
